draw_text_ctl: RTL
==================

DRAW_TEXT_CTL -- requirements
Module: draw_text_ctl

Interface
REQ-001 Parameter XPOS, default 11'd64: left pixel column of the 128x256 px text box.
REQ-002 Parameter YPOS, default 11'd64: top pixel line of the text box.
REQ-003 Parameter TEXT_RGB, default 12'h0F0: colour of set glyph pixels.
REQ-004 Parameter REVEAL_DIV, default 8'd2: frames per revealed character, legal range 1..255.
REQ-005 pclk  in  1  pixel clock; single clock domain.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 hcount_in, vcount_in  in  11 each  pixel position of the incoming timing stream.
REQ-008 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  incoming timing strobes.
REQ-009 rgb_in  in  12  background pixel.
REQ-010 text_en  in  1  overlay enable.
REQ-011 mode_req  in  1  requested text page: 0 = instructions, 1 = success.
REQ-012 char_yx  out  8  combinational character-ROM address {row[3:0], col[3:0]}.
REQ-013 rom_mode  out  1  registered page select driven to the character ROM.
REQ-014 char_code  in  7  combinational character-ROM data for char_yx.
REQ-015 font_addr  out  11  registered font-ROM address {char_code, glyph_line[3:0]}.
REQ-016 font_line  in  8  font-ROM data, valid one cycle after font_addr; bit 7 = leftmost pixel.
REQ-017 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  11/11/1/1/1/1/12  timing and pixel delayed by 3 cycles.
REQ-018 reveal_done  out  1  high while all 256 characters are revealed.

Function
REQ-019 rel_x = hcount_in - XPOS, rel_y = vcount_in - YPOS; pixel is in-box iff 0 <= rel_x < 128 and 0 <= rel_y < 256.
REQ-020 char_yx = {rel_y[7:4], rel_x[6:3]}; glyph_line = rel_y[3:0]; bit_sel = rel_x[2:0].
REQ-021 Stage 1 (end of cycle N): register font_addr, in-box flag, bit_sel, visible flag, timing, rgb_in.
REQ-022 Stage 2 (end of N+1): font_line arrives; register it with stage-1 sidebands.
REQ-023 Stage 3 (end of N+2): rgb_out = TEXT_RGB when in-box AND visible AND font_line[7-bit_sel] AND state != OFF AND not blanking; otherwise rgb_out = delayed rgb_in.
REQ-024 All timing outputs equal inputs delayed exactly 3 pclk cycles.
REQ-025 visible = (char_yx < reveal_cnt), reveal_cnt 9-bit, range 0..256.
REQ-026 frame_tick = (hcount_in == 0 AND vcount_in == 0).
REQ-027 rom_mode updates to mode_req only on frame_tick; a change clears reveal_cnt and frame divider to 0 in that cycle.
REQ-028 FSM states OFF, REVEAL, SHOWN.
REQ-029 OFF: reveal_cnt = 0; on text_en = 1 -> REVEAL.
REQ-030 REVEAL: frame divider counts frame_ticks 0..REVEAL_DIV-1; on wrap reveal_cnt increments; at reveal_cnt = 256 -> SHOWN.
REQ-031 SHOWN: reveal_cnt held at 256, reveal_done = 1; mode change on frame_tick -> REVEAL with reveal_cnt = 0.
REQ-032 text_en = 0 in any state -> OFF next cycle, counters cleared; takes priority over frame_tick and mode change.
REQ-033 reveal_cnt saturates at 256; never wraps.

Reset
REQ-034 On rst_n low, all registered outputs, pipeline stages, counters are 0, rom_mode = 0, state = OFF, reveal_done = 0.
REQ-035 Reset asserted mid-frame clears immediately; after release, output is valid from the 4th clock edge onward.

Structure
REQ-036 State encoding, box width/height (128/256), glyph size (8x16), pipeline depth (3) live in shared package text_pkg.
REQ-037 One sub-module natural: delay_line (parameterised width/depth) for timing and rgb sidebands.
REQ-038 Character ROM and font ROM stay external; no internal text storage.

Verification
REQ-039 Reset: rst_n = 0 mid-frame -> all outputs 0, state OFF; release -> rgb_out tracks rgb_in 3 cycles later.
REQ-040 text_en = 0, rgb_in = 12'h123 -> rgb_out = 12'h123 everywhere, 3-cycle latency.
REQ-041 text_en = 1, REVEAL_DIV = 1 -> reveal_cnt = 1 after first frame_tick, 256 after 256 frames, reveal_done = 1.
REQ-042 Pixel (XPOS+1, YPOS), char_code 7'h57, font_line 8'h40, reveal complete -> rgb_out = TEXT_RGB at output cycle.
REQ-043 mode_req 0->1 mid-frame -> rom_mode changes only at next (0,0); reveal_cnt = 0 on the same cycle.
REQ-044 text_en drops at frame_tick with pending mode change -> state OFF, reveal_cnt = 0, rom_mode unchanged.

Source files
------------

// File: rtl/draw_text_ctl_pkg.sv
// text_pkg: shared FSM encoding, box/glyph geometry and pipeline depth for the text overlay
package text_pkg;
   typedef enum logic [1:0] {ST_OFF, ST_REVEAL, ST_SHOWN} state_t;
   localparam int BOX_W = 128;
   localparam int BOX_H = 256;
   localparam int GLYPH_W = 8;
   localparam int GLYPH_H = 16;
   localparam int PIPE_DEPTH = 3;
   localparam logic [8:0] NUM_CHARS = 9'((BOX_W / GLYPH_W) * (BOX_H / GLYPH_H));
   function automatic logic in_box(input logic [10:0] rel_x, input logic [10:0] rel_y);
      return (rel_x < 11'(BOX_W)) && (rel_y < 11'(BOX_H));
   endfunction
endpackage

// File: rtl/draw_text_ctl_if.sv
// draw_text_ctl_if: one video timing/pixel stream; master drives it, slave consumes it
interface draw_text_ctl_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;
   modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_text_ctl_delay_line.sv
// delay_line: fixed-latency register chain for sideband signals
module delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             pclk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_pipe [DEPTH];
   // shift the input through DEPTH registers, all cleared by reset
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end
   assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/draw_text_ctl.sv
// draw_text_ctl: overlays a 16x16-character text page with a per-frame character reveal
module draw_text_ctl import text_pkg::*; #(
   parameter logic [10:0] XPOS       = 11'd64,
   parameter logic [10:0] YPOS       = 11'd64,
   parameter logic [11:0] TEXT_RGB   = 12'h0F0,
   parameter logic [7:0]  REVEAL_DIV = 8'd2
) (
   input  logic                   pclk,
   input  logic                   rst_n,
   draw_text_ctl_if.slave         vid_in,
   draw_text_ctl_if.master        vid_out,
   input  logic                   text_en,
   input  logic                   mode_req,
   output logic [7:0]             char_yx,
   output logic                   rom_mode,
   input  logic [6:0]             char_code,
   output logic [10:0]            font_addr,
   input  logic [7:0]             font_line,
   output logic                   reveal_done
);
   state_t      r_state, w_nstate;
   logic [8:0]  r_cnt, w_ncnt;
   logic [7:0]  r_div, w_ndiv;
   logic        r_mode, w_nmode;
   logic [10:0] w_rel_x, w_rel_y, r_font_addr;
   logic        w_tick, w_wrap, w_hit;
   logic        r_hit1, r_hit2;
   logic [2:0]  r_bit1, r_bit2;
   logic [7:0]  r_font2;
   logic [11:0] w_rgb2, r_rgb3;
   logic [25:0] w_tim;

   assign w_rel_x     = vid_in.hcount - XPOS;
   assign w_rel_y     = vid_in.vcount - YPOS;
   assign char_yx     = {w_rel_y[7:4], w_rel_x[6:3]};
   assign w_tick      = (vid_in.hcount == '0) && (vid_in.vcount == '0);
   assign w_wrap      = r_div == REVEAL_DIV - 8'd1;
   assign w_hit       = in_box(w_rel_x, w_rel_y) && ({1'b0, char_yx} < r_cnt) &&
                        (r_state != ST_OFF) && !(vid_in.hblnk || vid_in.vblnk);
   assign rom_mode    = r_mode;
   assign font_addr   = r_font_addr;
   assign reveal_done = r_state == ST_SHOWN;

   // next state: enable drop wins, then a page change on frame tick, then reveal progress
   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt;
      w_ndiv   = r_div;
      w_nmode  = r_mode;
      if (!text_en) begin
         w_nstate = ST_OFF;
         w_ncnt   = '0;
         w_ndiv   = '0;
      end else if (w_tick && (mode_req != r_mode)) begin
         w_nmode  = mode_req;
         w_nstate = ST_REVEAL;
         w_ncnt   = '0;
         w_ndiv   = '0;
      end else if (r_state == ST_OFF) begin
         w_nstate = ST_REVEAL;
         w_ncnt   = '0;
         w_ndiv   = '0;
      end else if ((r_state == ST_REVEAL) && w_tick) begin
         w_ndiv   = w_wrap ? '0 : r_div + 8'd1;
         w_ncnt   = (w_wrap && (r_cnt != NUM_CHARS)) ? r_cnt + 9'd1 : r_cnt;
         w_nstate = (w_ncnt == NUM_CHARS) ? ST_SHOWN : ST_REVEAL;
      end
   end

   // FSM state, reveal counter, frame divider and page select registers
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_OFF;
         r_cnt   <= '0;
         r_div   <= '0;
         r_mode  <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         r_div   <= w_ndiv;
         r_mode  <= w_nmode;
      end
   end

   // pixel pipeline: font address issue, font line capture, colour select
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_font_addr <= '0;
         r_hit1      <= 1'b0;
         r_bit1      <= '0;
         r_font2     <= '0;
         r_hit2      <= 1'b0;
         r_bit2      <= '0;
         r_rgb3      <= '0;
      end else begin
         r_font_addr <= {char_code, w_rel_y[3:0]};
         r_hit1      <= w_hit;
         r_bit1      <= w_rel_x[2:0];
         r_font2     <= font_line;
         r_hit2      <= r_hit1;
         r_bit2      <= r_bit1;
         r_rgb3      <= (r_hit2 && r_font2[3'd7 - r_bit2]) ? TEXT_RGB : w_rgb2;
      end
   end

   delay_line #(.WIDTH(12), .DEPTH(PIPE_DEPTH - 1)) u_rgb_dly (
      .pclk  (pclk),
      .rst_n (rst_n),
      .i_d   (vid_in.rgb),
      .o_q   (w_rgb2)
   );

   delay_line #(.WIDTH(26), .DEPTH(PIPE_DEPTH)) u_tim_dly (
      .pclk  (pclk),
      .rst_n (rst_n),
      .i_d   ({vid_in.hcount, vid_in.vcount, vid_in.hsync, vid_in.vsync, vid_in.hblnk, vid_in.vblnk}),
      .o_q   (w_tim)
   );

   assign vid_out.hcount = w_tim[25:15];
   assign vid_out.vcount = w_tim[14:4];
   assign vid_out.hsync  = w_tim[3];
   assign vid_out.vsync  = w_tim[2];
   assign vid_out.hblnk  = w_tim[1];
   assign vid_out.vblnk  = w_tim[0];
   assign vid_out.rgb    = r_rgb3;
endmodule
